text_writer: RTL and testbench
==============================

Name: text_writer

Overview:
- Writer side of the text-mode video path. It accepts a byte stream from the CPU or a terminal source through a valid/ready handshake.
- It interprets printable characters and basic control codes, and writes character codes into the 80x30 text RAM that the video block reads for display.
- It keeps the cursor position and a hardware scroll offset, top_row_o, which the video block adds to its character-row index.

Parameters:
- COLS, 80, characters per row (640/8).
- ROWS, 30, character rows (480/16).
- ADDR_W, 12, text RAM address width (COLS*ROWS = 2400 fits).
- FILL, 8'h20, character written when clearing (space).

Ports:
- clk_i  in  1  pixel/system clock.
- rst_n_i  in  1  asynchronous, active-low reset.
- data_i  in  8  character/control byte.
- valid_i  in  1  data_i valid.
- ready_o  out  1  block can accept a byte; transfer occurs when valid_i & ready_o at posedge.
- ram_we_o  out  1  text RAM write strobe, one cycle per write.
- ram_addr_o  out  ADDR_W  text RAM address = phys_row*COLS + col.
- ram_data_o  out  8  text RAM write data.
- cursor_x_o  out  7  cursor column, 0..COLS-1.
- cursor_y_o  out  5  cursor logical row, 0..ROWS-1.
- top_row_o  out  5  physical RAM row shown at the top of the screen, 0..ROWS-1.
- busy_o  out  1  high in a clear state (= ~ready_o).

Behaviour:
- Reset is asynchronous on rst_n_i low, clock clk_i.
- Reset values:
  - state=CLR_SCREEN, clear counter=0.
  - cursor_x_o=0, cursor_y_o=0, top_row_o=0.
  - ram_we_o=0, ram_addr_o=0, ram_data_o=0.
  - ready_o=0, busy_o=1.
- All outputs are registered. ready_o = (state==IDLE).
- Physical row = (cursor_y + top_row) mod ROWS, computed without a divider by add-and-subtract-ROWS-if->=ROWS.
- Address = (phys_row<<6)+(phys_row<<4)+col when COLS=80; the generic case uses phys_row*COLS.
- States:
  - IDLE
  - CLR_LINE: clear one physical row, COLS writes.
  - CLR_SCREEN: clear all COLS*ROWS addresses.
- CLR_SCREEN:
  - Writes FILL to addresses 0..COLS*ROWS-1, one per cycle.
  - After the last write: IDLE, cursor=(0,0), top_row=0.
  - 2400 cycles at default geometry.
- Accepted byte in IDLE, with all effects at the accepting edge and the RAM write visible in the next cycle:
  - Printable 0x20..0x7E: ram_we_o=1, addr=current cursor cell, data=byte.
    - If x<COLS-1: x+1.
    - Otherwise: x=0 and perform a newline.
  - 0x0D CR: x=0, no write.
  - 0x0A LF: newline, x unchanged.
  - 0x08 BS: if x>0 then x-1, no write. At x=0 no change.
  - 0x0C FF: enter CLR_SCREEN; cursor and top_row become 0 when it completes.
  - Any other byte: ignored, accepted, no state change.
- Newline:
  - If y<ROWS-1: y+1.
  - Otherwise (scroll): y stays ROWS-1.
    - top_row becomes (top_row+1) mod ROWS. It wraps 29->0.
    - Enter CLR_LINE targeting the physical row equal to the old top_row, which is the new bottom row.
- CLR_LINE:
  - Writes FILL to cols 0..COLS-1 of the target row, one per cycle, then IDLE (COLS cycles).
  - When the accepting byte also caused a char write, that write occupies the first cycle after acceptance.
  - The clear writes follow immediately after, with no dropped or merged writes.
- Handshake:
  - valid_i while ready_o=0: no effect. The source holds data_i.
  - Back-to-back bytes are accepted every cycle in IDLE when no scroll or clear is triggered.
- ram_we_o is 0 in any cycle without a write. ram_addr_o and ram_data_o hold their last values.
- Reset asserted mid-operation aborts any state immediately and restarts the reset sequence, so the screen is cleared again.

Test Plan:
- Reset release -> ready_o=0 for exactly 2400 cycles with 2400 writes of 0x20 at addresses 0..2399 in order. Then ready_o=1, cursor (0,0), top_row 0.
- Send 'A'(0x41),'B' after init -> writes (addr0,0x41),(addr1,0x42) on consecutive cycles, cursor_x=2. Then 0x08 -> x=1. Then 0x0D -> x=0. Then 0x08 -> x stays 0.
- 80 printable bytes on row 0 -> last write at addr 79, cursor becomes (0,1) with no extra write. Then 0x0A -> cursor_y=2, x=0.
- Cursor at (5,29), top_row 0, send 0x0A -> top_row=1, cursor (5,29), ready_o low 80 cycles, FILL written to addrs 0..79. Next 'X' writes addr 0*80+5=5, since phys_row=(29+1) mod 30=0.
- top_row=29, cursor (79,29), send 'Z' -> write at phys_row 28, addr 2319. Then top_row wraps to 0, and FILL is written to addrs 2320..2399. Cursor becomes (0,29).
- Assert rst_n_i during CLR_LINE, and separately send 0x0C mid-session with 0x41 held valid during the clear -> restart clear from addr 0, and the held byte is not accepted until ready_o=1.

Source files
------------

// File: rtl/text_writer.sv
// Text-mode writer: turns a byte stream into character writes for an
// 80x30 text RAM, tracking the cursor and a hardware scroll offset.
// Scrolling never moves RAM contents. Instead top_row_o advances, and the
// row that becomes the new bottom line is blanked by a short clear sequence.
module text_writer #(
  parameter int          COLS   = 80,
  parameter int          ROWS   = 30,
  parameter int          ADDR_W = 12,
  parameter logic [7:0]  FILL   = 8'h20
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [7:0]        data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [7:0]        ram_data_o,
  output logic [6:0]        cursor_x_o,
  output logic [4:0]        cursor_y_o,
  output logic [4:0]        top_row_o,
  output logic              busy_o
);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_CLR_LINE   = 2'd1;
  localparam logic [1:0] ST_CLR_SCREEN = 2'd2;

  localparam logic [ADDR_W-1:0] LINE_LAST   = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] SCREEN_LAST = ADDR_W'(COLS * ROWS - 1);
  localparam logic [6:0]        X_LAST      = 7'(COLS - 1);
  localparam logic [4:0]        Y_LAST      = 5'(ROWS - 1);

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  logic [1:0]        state_q,    state_d;
  logic [ADDR_W-1:0] cnt_q,      cnt_d;
  logic [6:0]        x_q,        x_d;
  logic [4:0]        y_q,        y_d;
  logic [4:0]        top_q,      top_d;
  logic [4:0]        line_row_q, line_row_d;
  logic              ready_q,    ready_d;
  logic              we_q,       we_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic [7:0]        wdata_q,    wdata_d;

  logic              newline;
  logic [ADDR_W-1:0] cur_addr;

  // (a + b) mod ROWS for operands already in 0..ROWS-1: one conditional
  // subtract is enough, so no divider is needed.
  function automatic logic [4:0] wrap_row(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= 6'(ROWS)) sum = sum - 6'(ROWS);
    return sum[4:0];
  endfunction

  // First RAM address of a physical row. The default 80-column geometry
  // reduces to two shifts and an add (row*64 + row*16).
  function automatic logic [ADDR_W-1:0] row_base(input logic [4:0] row);
    logic [ADDR_W-1:0] r;
    r = ADDR_W'(row);
    if (COLS == 80) return (r << 6) + (r << 4);
    else            return ADDR_W'(int'(row) * COLS);
  endfunction

  // Address of the cell under the cursor, after applying the scroll offset.
  always_comb begin
    cur_addr = row_base(wrap_row(y_q, top_q)) + ADDR_W'(x_q);
  end

  // Next-state logic: byte interpretation in IDLE, write sequencing while clearing.
  always_comb begin
    // NOTE: every signal gets a default before any branch so that no path
    // leaves one unassigned, which would infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    x_d        = x_q;
    y_d        = y_q;
    top_d      = top_q;
    line_row_d = line_row_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    newline    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          if (data_i >= 8'h20 && data_i <= 8'h7E) begin
            we_d    = 1'b1;
            addr_d  = cur_addr;
            wdata_d = data_i;
            if (x_q < X_LAST) begin
              x_d = x_q + 7'd1;
            end else begin
              x_d     = 7'd0;
              newline = 1'b1;
            end
          end else begin
            case (data_i)
              CH_CR: x_d = 7'd0;
              CH_LF: newline = 1'b1;
              CH_BS: if (x_q != 7'd0) x_d = x_q - 7'd1;
              CH_FF: begin
                state_d = ST_CLR_SCREEN;
                cnt_d   = '0;
              end
              default: ;
            endcase
          end

          // Newline on the last line scrolls: the old top row becomes the
          // new bottom row and is blanked by the CLR_LINE sequence.
          if (newline) begin
            if (y_q < Y_LAST) begin
              y_d = y_q + 5'd1;
            end else begin
              top_d      = wrap_row(top_q, 5'd1);
              line_row_d = top_q;
              state_d    = ST_CLR_LINE;
              cnt_d      = '0;
            end
          end
        end
      end

      ST_CLR_LINE: begin
        we_d    = 1'b1;
        addr_d  = row_base(line_row_q) + cnt_q;
        wdata_d = FILL;
        if (cnt_q == LINE_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_CLR_SCREEN: begin
        we_d    = 1'b1;
        addr_d  = cnt_q;
        wdata_d = FILL;
        if (cnt_q == SCREEN_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          x_d     = 7'd0;
          y_d     = 5'd0;
          top_d   = 5'd0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_CLR_SCREEN;
        cnt_d   = '0;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  // State and output registers; reset restarts the full-screen clear.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_CLR_SCREEN;
      cnt_q      <= '0;
      x_q        <= 7'd0;
      y_q        <= 5'd0;
      top_q      <= 5'd0;
      line_row_q <= 5'd0;
      ready_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 8'h00;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      x_q        <= x_d;
      y_q        <= y_d;
      top_q      <= top_d;
      line_row_q <= line_row_d;
      ready_q    <= ready_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign ready_o    = ready_q;
  assign busy_o     = ~ready_q;
  assign ram_we_o   = we_q;
  assign ram_addr_o = addr_q;
  assign ram_data_o = wdata_q;
  assign cursor_x_o = x_q;
  assign cursor_y_o = y_q;
  assign top_row_o  = top_q;

  // Cursor and scroll offset always stay inside the screen.
  cursor_in_range: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (x_q <= X_LAST) && (y_q <= Y_LAST) && (top_q <= Y_LAST));

endmodule

// File: tb/tb_text_writer.sv
// Directed bench for text_writer: a vector table for single-byte behaviour
// plus hand-written sequences for clears, scrolling and reset.
module tb_text_writer;

  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int ADDR_W = 12;

  logic              clk_i   = 1'b0;
  logic              rst_n_i = 1'b0;
  logic [7:0]        data_i  = 8'h00;
  logic              valid_i = 1'b0;
  logic              ready_o;
  logic              ram_we_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [7:0]        ram_data_o;
  logic [6:0]        cursor_x_o;
  logic [4:0]        cursor_y_o;
  logic [4:0]        top_row_o;
  logic              busy_o;

  text_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .FILL(8'h20)) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .ram_we_o   (ram_we_o),
    .ram_addr_o (ram_addr_o),
    .ram_data_o (ram_data_o),
    .cursor_x_o (cursor_x_o),
    .cursor_y_o (cursor_y_o),
    .top_row_o  (top_row_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [11:0] addr;
    logic [7:0]  data;
  } wr_t;
  wr_t wq[$];

  // Write log, sampled on the falling edge.
  always @(negedge clk_i) begin
    if (rst_n_i && ram_we_o) wq.push_back(wr_t'{ram_addr_o, ram_data_o});
  end

  typedef struct {
    logic [7:0]  din;
    logic [6:0]  x;
    logic [4:0]  y;
    logic        we;
    logic [11:0] addr;
    logic [7:0]  data;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits (on falling edges) until ready_o is high; counts the low samples.
  task automatic wait_ready(input string name, input int budget, output int low_cycles);
    low_cycles = 0;
    while (!ready_o && low_cycles < budget) begin
      low_cycles++;
      @(negedge clk_i);
    end
    if (!ready_o) begin
      total++;
      bad++;
      $display("FAIL %s: ready_o still low after %0d cycles", name, low_cycles);
    end
  endtask

  // Offers one byte, returns on the falling edge after it was accepted.
  task automatic send(input logic [7:0] b);
    int lc;
    wait_ready("send_wait", 3000, lc);
    data_i  = b;
    valid_i = 1'b1;
    @(posedge clk_i);
    #1 valid_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic flush();
    #1 wq.delete();
  endtask

  // Index of the first logged write in wq[from +: n] that is not
  // (base + k, d); -1 when all match.
  function automatic int seq_bad(input int from, input int n, input int base, input logic [7:0] d);
    for (int k = 0; k < n; k++) begin
      if (from + k >= wq.size()) return k;
      if (wq[from+k].addr !== 12'(base + k) || wq[from+k].data !== d) return k;
    end
    return -1;
  endfunction

  // Checks reset values while rst_n_i is low, releases it and checks the
  // full-screen clear that follows.
  task automatic run_init(input string tag);
    int lc;
    @(negedge clk_i);
    check({tag, " rst ready"}, 32'(ready_o), 32'd0);
    check({tag, " rst busy"},  32'(busy_o),  32'd1);
    check({tag, " rst we"},    32'(ram_we_o), 32'd0);
    check({tag, " rst addr"},  32'(ram_addr_o), 32'd0);
    check({tag, " rst data"},  32'(ram_data_o), 32'd0);
    check({tag, " rst cursor"}, 32'({cursor_x_o, cursor_y_o, top_row_o}), 32'd0);
    wq.delete();
    #1 rst_n_i = 1'b1;
    wait_ready({tag, " clear"}, 3000, lc);
    check({tag, " ready low cycles"}, 32'(lc), 32'd2400);
    #1;
    check({tag, " clear write count"}, 32'(wq.size()), 32'd2400);
    check({tag, " clear order"}, 32'(seq_bad(0, 2400, 0, 8'h20)), 32'hFFFF_FFFF);
    check({tag, " cursor x"}, 32'(cursor_x_o), 32'd0);
    check({tag, " cursor y"}, 32'(cursor_y_o), 32'd0);
    check({tag, " top row"},  32'(top_row_o),  32'd0);
    check({tag, " busy"},     32'(busy_o),     32'd0);
    @(negedge clk_i);
    check({tag, " idle we"},   32'(ram_we_o),   32'd0);
    check({tag, " hold addr"}, 32'(ram_addr_o), 32'd2399);
    check({tag, " hold data"}, 32'(ram_data_o), 32'h20);
  endtask

  vec_t vecs[14];

  initial begin
    int lc;
    int fb;

    vecs[0]  = '{8'h41, 7'd1, 5'd0, 1'b1, 12'd0,  8'h41};
    vecs[1]  = '{8'h42, 7'd2, 5'd0, 1'b1, 12'd1,  8'h42};
    vecs[2]  = '{8'h08, 7'd1, 5'd0, 1'b0, 12'd0,  8'h00};
    vecs[3]  = '{8'h0D, 7'd0, 5'd0, 1'b0, 12'd0,  8'h00};
    vecs[4]  = '{8'h08, 7'd0, 5'd0, 1'b0, 12'd0,  8'h00};
    vecs[5]  = '{8'h01, 7'd0, 5'd0, 1'b0, 12'd0,  8'h00};
    vecs[6]  = '{8'h7E, 7'd1, 5'd0, 1'b1, 12'd0,  8'h7E};
    vecs[7]  = '{8'h7F, 7'd1, 5'd0, 1'b0, 12'd0,  8'h00};
    vecs[8]  = '{8'h1F, 7'd1, 5'd0, 1'b0, 12'd0,  8'h00};
    vecs[9]  = '{8'h0A, 7'd1, 5'd1, 1'b0, 12'd0,  8'h00};
    vecs[10] = '{8'h20, 7'd2, 5'd1, 1'b1, 12'd81, 8'h20};
    vecs[11] = '{8'h0D, 7'd0, 5'd1, 1'b0, 12'd0,  8'h00};
    vecs[12] = '{8'h0A, 7'd0, 5'd2, 1'b0, 12'd0,  8'h00};
    vecs[13] = '{8'h08, 7'd0, 5'd2, 1'b0, 12'd0,  8'h00};

    // Power-up clear.
    run_init("init");

    // Single bytes, back to back.
    for (int i = 0; i < 14; i++) begin
      send(vecs[i].din);
      check($sformatf("vec%0d ready", i), 32'(ready_o),    32'd1);
      check($sformatf("vec%0d x", i),     32'(cursor_x_o), 32'(vecs[i].x));
      check($sformatf("vec%0d y", i),     32'(cursor_y_o), 32'(vecs[i].y));
      check($sformatf("vec%0d we", i),    32'(ram_we_o),   32'(vecs[i].we));
      if (vecs[i].we) begin
        check($sformatf("vec%0d addr", i), 32'(ram_addr_o), 32'(vecs[i].addr));
        check($sformatf("vec%0d data", i), 32'(ram_data_o), 32'(vecs[i].data));
      end
    end

    // Form feed with the next byte held valid during the clear.
    send(8'h0C);
    flush();
    data_i  = 8'h41;
    valid_i = 1'b1;
    wait_ready("ff clear", 3000, lc);
    check("ff ready low cycles", 32'(lc), 32'd2400);
    check("ff cursor after clear", 32'({cursor_x_o, cursor_y_o, top_row_o}), 32'd0);
    @(posedge clk_i);
    #1 valid_i = 1'b0;
    @(negedge clk_i);
    #1;
    check("ff write count", 32'(wq.size()), 32'd2401);
    check("ff clear order", 32'(seq_bad(0, 2400, 0, 8'h20)), 32'hFFFF_FFFF);
    check("ff held byte write", 32'(seq_bad(2400, 1, 0, 8'h41)), 32'hFFFF_FFFF);
    check("ff held byte x", 32'(cursor_x_o), 32'd1);

    // Fill row 0 completely: wrap to (0,1) without an extra write.
    send(8'h0D);
    flush();
    for (int i = 0; i < COLS; i++) send(8'(8'h21 + i));
    check("row wrap x", 32'(cursor_x_o), 32'd0);
    check("row wrap y", 32'(cursor_y_o), 32'd1);
    check("row wrap ready", 32'(ready_o), 32'd1);
    @(negedge clk_i);
    check("row wrap no extra we", 32'(ram_we_o), 32'd0);
    fb = -1;
    for (int i = 0; i < COLS; i++)
      if (fb < 0 && (i >= wq.size() || wq[i].addr !== 12'(i) || wq[i].data !== 8'(8'h21 + i))) fb = i;
    check("row wrap write order", 32'(fb), 32'hFFFF_FFFF);
    check("row wrap write count", 32'(wq.size()), 32'd80);
    send(8'h0A);
    check("lf after wrap x", 32'(cursor_x_o), 32'd0);
    check("lf after wrap y", 32'(cursor_y_o), 32'd2);

    // Walk down to the last line and scroll once from (5,29).
    for (int i = 0; i < 27; i++) send(8'h0A);
    check("bottom y", 32'(cursor_y_o), 32'd29);
    check("bottom top_row", 32'(top_row_o), 32'd0);
    send(8'h0D);
    for (int i = 0; i < 5; i++) send(8'h20);
    flush();
    send(8'h0A);
    check("scroll top_row", 32'(top_row_o), 32'd1);
    check("scroll cursor", 32'({cursor_x_o, cursor_y_o}), 32'({7'd5, 5'd29}));
    check("scroll ready", 32'(ready_o), 32'd0);
    check("scroll busy", 32'(busy_o), 32'd1);
    wait_ready("scroll clear", 200, lc);
    check("scroll ready low cycles", 32'(lc), 32'd80);
    #1;
    check("scroll write count", 32'(wq.size()), 32'd80);
    check("scroll clear order", 32'(seq_bad(0, 80, 0, 8'h20)), 32'hFFFF_FFFF);
    send(8'h58);
    check("post scroll we", 32'(ram_we_o), 32'd1);
    check("post scroll addr", 32'(ram_addr_o), 32'd5);
    check("post scroll data", 32'(ram_data_o), 32'h58);
    check("post scroll x", 32'(cursor_x_o), 32'd6);

    // Scroll until top_row is 29, then write at (79,29) and wrap the offset.
    for (int i = 0; i < 28; i++) send(8'h0A);
    wait_ready("scroll28", 200, lc);
    check("top_row 29", 32'(top_row_o), 32'd29);
    send(8'h0D);
    for (int i = 0; i < 79; i++) send(8'h41);
    check("before wrap cursor", 32'({cursor_x_o, cursor_y_o}), 32'({7'd79, 5'd29}));
    flush();
    send(8'h5A);
    check("wrap char we", 32'(ram_we_o), 32'd1);
    check("wrap char addr", 32'(ram_addr_o), 32'd2319);
    check("wrap char data", 32'(ram_data_o), 32'h5A);
    check("wrap top_row", 32'(top_row_o), 32'd0);
    check("wrap cursor", 32'({cursor_x_o, cursor_y_o}), 32'({7'd0, 5'd29}));
    check("wrap ready", 32'(ready_o), 32'd0);
    wait_ready("wrap clear", 200, lc);
    check("wrap ready low cycles", 32'(lc), 32'd80);
    #1;
    check("wrap write count", 32'(wq.size()), 32'd81);
    check("wrap char first", 32'(seq_bad(0, 1, 2319, 8'h5A)), 32'hFFFF_FFFF);
    check("wrap clear order", 32'(seq_bad(1, 80, 2320, 8'h20)), 32'hFFFF_FFFF);

    // Reset in the middle of a line clear restarts the screen clear.
    send(8'h0A);
    check("pre-reset top_row", 32'(top_row_o), 32'd1);
    repeat (10) @(negedge clk_i);
    #1 rst_n_i = 1'b0;
    #1;
    check("async reset we", 32'(ram_we_o), 32'd0);
    check("async reset top_row", 32'(top_row_o), 32'd0);
    check("async reset ready", 32'(ready_o), 32'd0);
    run_init("reinit");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
